// File: rtl/lzc_normalize.sv
// lzc_normalize: two-stage leading-zero count / normalize pipeline with valid/ready handshake.
// Optional macro LAU_LZC_NORM_SHIFT_EN builds the normalizing shifter and the norm_o register.

package lau_pkg;
    typedef enum logic {FAST, SMALL} speed_e;
endpackage

// PrefixOr: y[i] = |a[i:0]; FAST is a log-depth doubling scan, SMALL a ripple chain.
module PrefixOr #(
    parameter int              width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic [width-1:0] a,
    output logic [width-1:0] y
);
    localparam int unsigned levels = $clog2(width);

    if (speed == lau_pkg::FAST) begin : g_fast
        always_comb begin
            logic [width-1:0] v;
            v = a;
            for (int unsigned k = 0; k < levels; k++) begin
                v = v | (v << (1 << k));
            end
            y = v;
        end
    end else begin : g_small
        always_comb begin
            logic acc;
            acc = 1'b0;
            y   = '0;
            for (int unsigned i = 0; i < width; i++) begin
                acc  = acc | a[i];
                y[i] = acc;
            end
        end
    end
endmodule

module lzc_normalize #(
    parameter int              width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [width-1:0]           data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(width+1)-1:0] count_o,
    output logic                       zero_o,
    output logic [width-1:0]           norm_o
);
    localparam int cw = $clog2(width+1);

    logic             s1_valid;
    logic [width-1:0] s1_data;
    logic             s2_valid;
    logic [cw-1:0]    s2_count;
    logic             s2_zero;
    logic             s1_load;
    logic             s2_load;
    logic [width-1:0] rev;
    logic [width-1:0] pre;
    logic [cw-1:0]    count_c;
    logic             zero_c;

    assign s2_load = !s2_valid || ready_i;
    assign s1_load = !s1_valid || s2_load;
    assign ready_o = s1_load;

    // Reversing the operand turns "leading ones from the MSB" into a low-to-high prefix-OR.
    assign rev = {<<{s1_data}};

    PrefixOr #(
        .width(width),
        .speed(speed)
    ) u_prefix (
        .a(rev),
        .y(pre)
    );

    // Every set prefix bit marks a position at or below the leading one.
    always_comb begin
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < width; i++) begin
            ones = ones + 32'(pre[i]);
        end
        count_c = cw'(width - ones);
    end

    assign zero_c = !pre[width-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (s1_load) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_data <= data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_count <= '0;
            s2_zero  <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_count <= count_c;
                s2_zero  <= zero_c;
            end
        end
    end

`ifdef LAU_LZC_NORM_SHIFT_EN
    logic [width-1:0] s2_norm;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_norm <= '0;
        end else if (s2_load && s1_valid) begin
            s2_norm <= s1_data << count_c;
        end
    end

    assign norm_o = s2_norm;
`else
    assign norm_o = '0;
`endif

    assign valid_o = s2_valid;
    assign count_o = s2_count;
    assign zero_o  = s2_zero;
endmodule

// File: tb/tb_lzc_normalize.sv
// tb_lzc_normalize: directed vectors, back-pressure/streaming/reset sequences and a randomized
// run against a shift-and-count reference model; norm expectations follow LAU_LZC_NORM_SHIFT_EN.
module tb_lzc_normalize;
    localparam int width = 8;
    localparam int cw    = $clog2(width+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_i = 1'b1;
    logic [width-1:0] data_i = '0;
    logic             ready_o;
    logic             valid_o;
    logic [cw-1:0]    count_o;
    logic             zero_o;
    logic [width-1:0] norm_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lzc_normalize #(
        .width(width),
        .speed(lau_pkg::FAST)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .count_o(count_o),
        .zero_o (zero_o),
        .norm_o (norm_o)
    );

    typedef struct {
        logic [7:0] data;
        int         lz;
        logic       zero;
        logic [7:0] norm;
    } vec_t;

    typedef struct {
        int         lz;
        logic       zero;
        logic [7:0] norm;
    } exp_t;

    vec_t vecs[8];
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] shown_norm(input logic [7:0] full);
`ifdef LAU_LZC_NORM_SHIFT_EN
        return full;
`else
        return full & 8'h00;
`endif
    endfunction

    // Normalize by doubling until the MSB is set, counting the doublings.
    function automatic exp_t model(input logic [7:0] d);
        exp_t       e;
        logic [7:0] v;
        v      = d;
        e.lz   = 0;
        e.zero = (d == 8'h00);
        if (e.zero) begin
            e.lz = width;
        end else begin
            while (v < 8'h80) begin
                v    = v << 1;
                e.lz = e.lz + 1;
            end
        end
        e.norm = shown_norm(e.zero ? 8'h00 : v);
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic exp_rdy;
        logic out_x;
        logic in_x;

        vecs[0] = '{8'h10, 3, 1'b0, 8'h80};
        vecs[1] = '{8'h00, 8, 1'b1, 8'h00};
        vecs[2] = '{8'h81, 0, 1'b0, 8'h81};
        vecs[3] = '{8'h01, 7, 1'b0, 8'h80};
        vecs[4] = '{8'h7F, 1, 1'b0, 8'hFE};
        vecs[5] = '{8'h03, 6, 1'b0, 8'hC0};
        vecs[6] = '{8'hFF, 0, 1'b0, 8'hFF};
        vecs[7] = '{8'h2C, 2, 1'b0, 8'hB0};

        @(negedge clk);
        check("rst_valid", 32'(valid_o), 32'(0));
        check("rst_count", 32'(count_o), 32'(0));
        check("rst_zero",  32'(zero_o),  32'(0));
        check("rst_norm",  32'(norm_o),  32'(0));
        check("rst_ready", 32'(ready_o), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            data_i  = vecs[i].data;
            step();
            valid_i = 1'b0;
            data_i  = 8'($urandom);
            @(negedge clk);
            check("vec_latency", 32'(valid_o), 32'(0));
            step();
            @(negedge clk);
            check("vec_valid", 32'(valid_o), 32'(1));
            check("vec_count", 32'(count_o), 32'(vecs[i].lz));
            check("vec_zero",  32'(zero_o),  32'(vecs[i].zero));
            check("vec_norm",  32'(norm_o),  32'(shown_norm(vecs[i].norm)));
            step();
        end

        // Back-pressure: two words fill the pipe, the third waits.
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h01;
        step();
        data_i = 8'h02;
        step();
        data_i = 8'h04;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_ready_low", 32'(ready_o), 32'(0));
            check("bp_valid_hold", 32'(valid_o), 32'(1));
            check("bp_count_hold", 32'(count_o), 32'(7));
            step();
        end
        ready_i = 1'b1;
        @(negedge clk);
        check("bp_ready_pass", 32'(ready_o), 32'(1));
        check("bp_count0", 32'(count_o), 32'(7));
        step();
        valid_i = 1'b0;
        @(negedge clk);
        check("bp_valid1", 32'(valid_o), 32'(1));
        check("bp_count1", 32'(count_o), 32'(6));
        step();
        @(negedge clk);
        check("bp_valid2", 32'(valid_o), 32'(1));
        check("bp_count2", 32'(count_o), 32'(5));
        step();
        @(negedge clk);
        check("bp_empty", 32'(valid_o), 32'(0));
        step();

        // Streaming at one word per cycle.
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                valid_i = 1'b1;
                data_i  = 8'h80 >> c;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
            if (c >= 2) begin
                check("stream_valid", 32'(valid_o), 32'(1));
                check("stream_count", 32'(count_o), 32'(c - 2));
                check("stream_norm",  32'(norm_o),  32'(shown_norm(8'h80)));
            end else begin
                check("stream_lead", 32'(valid_o), 32'(0));
            end
            step();
        end

        // Reset with both stages full.
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h01;
        step();
        data_i = 8'h02;
        step();
        valid_i = 1'b0;
        @(negedge clk);
        check("rm_full_valid", 32'(valid_o), 32'(1));
        check("rm_full_ready", 32'(ready_o), 32'(0));
        step();
        rst = 1'b1;
        #1;
        check("rm_async_valid", 32'(valid_o), 32'(0));
        check("rm_async_count", 32'(count_o), 32'(0));
        check("rm_async_ready", 32'(ready_o), 32'(1));
        step();
        rst     = 1'b0;
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h20;
        step();
        valid_i = 1'b0;
        @(negedge clk);
        check("rm_no_stale", 32'(valid_o), 32'(0));
        step();
        @(negedge clk);
        check("rm_first_valid", 32'(valid_o), 32'(1));
        check("rm_first_count", 32'(count_o), 32'(2));
        step();
        @(negedge clk);
        check("rm_after", 32'(valid_o), 32'(0));
        step();

        // Randomized traffic against the queue-based reference.
        for (int c = 0; c < 400; c++) begin
            valid_i = ($urandom_range(0, 9) < 7);
            data_i  = 8'($urandom) >> $urandom_range(0, 8);
            ready_i = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            exp_rdy = (q.size() < 2) || ready_i;
            check("rand_ready", 32'(ready_o), 32'(exp_rdy));
            if (q.size() == 0) begin
                check("rand_idle", 32'(valid_o), 32'(0));
            end else if (valid_o) begin
                check("rand_count", 32'(count_o), 32'(q[0].lz));
                check("rand_zero",  32'(zero_o),  32'(q[0].zero));
                check("rand_norm",  32'(norm_o),  32'(q[0].norm));
            end
            out_x = valid_o && ready_i;
            in_x  = valid_i && exp_rdy;
            e     = model(data_i);
            step();
            if (out_x && q.size() > 0) void'(q.pop_front());
            if (in_x) q.push_back(e);
        end

        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            @(negedge clk);
            if (valid_o) begin
                check("drain_count", 32'(count_o), 32'(q[0].lz));
                out_x = 1'b1;
            end else begin
                out_x = 1'b0;
            end
            step();
            if (out_x) void'(q.pop_front());
        end
        check("drain_left", 32'(q.size()), 32'(0));
        @(negedge clk);
        check("drain_idle", 32'(valid_o), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
